// File: rtl/seq_addsub_pkg.sv
// Shared types and elaboration-time helpers for the sequential add/subtract unit.
package seq_addsub_pkg;

  // Operation sequencing: wait for operands, ripple chunks, present result.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  // Ceiling log2, used to size the chunk index register.
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

  // Number of chunk steps needed to cover one operand.
  function automatic int nchunk(input int width, input int chunk);
    return width / chunk;
  endfunction

  // Index register width; a single-chunk configuration still gets one bit.
  function automatic int idx_width(input int width, input int chunk);
    return (nchunk(width, chunk) > 1) ? clog2(nchunk(width, chunk)) : 1;
  endfunction

endpackage

// File: rtl/seq_addsub_rca.sv
// Purely combinational CHUNK-bit ripple-carry adder slice.
module rca_chunk #(
  parameter int CHUNK = 8
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             cin,
  output logic [CHUNK-1:0] s,
  output logic             cout
);

  logic c;

  // Bit-serial ripple: each stage consumes the carry of the previous one.
  always_comb begin
    s = '0;
    c = cin;
    for (int i = 0; i < CHUNK; i++) begin
      s[i] = a[i] ^ b[i] ^ c;
      c    = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
    end
    cout = c;
  end

endmodule

// File: rtl/seq_addsub.sv
// Multi-cycle add/subtract unit: one rca_chunk is time-multiplexed over the
// operand, CHUNK bits per clock, behind valid/ready handshakes on both sides.
module seq_addsub
  import seq_addsub_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Sum,
  output logic             Cout,
  output logic             Ovf,
  output logic             Zero
);

  localparam int NCHUNK = nchunk(WIDTH, CHUNK);
  localparam int IDXW   = idx_width(WIDTH, CHUNK);
  localparam logic [IDXW-1:0] LAST = IDXW'(NCHUNK - 1);

  state_t state, state_nxt;

  // Operands and result are kept chunk-indexed so the slice mux is a plain index.
  logic [NCHUNK-1:0][CHUNK-1:0] a_q, b_q, sum_q, sum_nxt;
  logic                         carry_q;
  logic [IDXW-1:0]              idx_q;

  logic [CHUNK-1:0] s_chunk;
  logic             c_chunk;
  logic             accept;
  logic             step;
  logic             last;

  assign accept = (state == IDLE) && in_valid;
  assign step   = (state == CALC);
  assign last   = (idx_q == LAST);

  // Single adder slice, fed by the chunk selected by idx_q.
  rca_chunk #(.CHUNK(CHUNK)) u_rca (
    .a    (a_q[idx_q]),
    .b    (b_q[idx_q]),
    .cin  (carry_q),
    .s    (s_chunk),
    .cout (c_chunk)
  );

  // Result with the current chunk merged in; flags on the final step see all chunks.
  always_comb begin
    sum_nxt        = sum_q;
    sum_nxt[idx_q] = s_chunk;
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state and handshake outputs.
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = CALC;
      end
      CALC: begin
        if (last) state_nxt = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Operand capture and chunk-by-chunk accumulation; flags settle on the last step
  // and then hold until the next operation's final step.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q     <= '0;
      b_q     <= '0;
      carry_q <= 1'b0;
      idx_q   <= '0;
      sum_q   <= '0;
      Cout    <= 1'b0;
      Ovf     <= 1'b0;
      Zero    <= 1'b0;
    end else if (accept) begin
      // Subtract is A + ~B + 1: invert B up front and seed the carry with Sub.
      a_q     <= A;
      b_q     <= B ^ {WIDTH{Sub}};
      carry_q <= Sub;
      idx_q   <= '0;
    end else if (step) begin
      sum_q   <= sum_nxt;
      carry_q <= c_chunk;
      idx_q   <= idx_q + 1'b1;
      if (last) begin
        Cout <= c_chunk;
        // Overflow: same-signed addends producing a differently-signed result.
        Ovf  <= (a_q[NCHUNK-1][CHUNK-1] == b_q[NCHUNK-1][CHUNK-1]) &&
                (s_chunk[CHUNK-1] != a_q[NCHUNK-1][CHUNK-1]);
        Zero <= ~|sum_nxt;
      end
    end
  end

  assign Sum = sum_q;

endmodule
